// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution sequencer: FSM encoding, default tick
// dividers and the ecall display code used by the datapath's LED logic.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam int unsigned DIV0_DEF = 100000000;
  localparam int unsigned DIV1_DEF = 10000000;
  localparam int unsigned DIV2_DEF = 2000000;
  localparam int unsigned DIV3_DEF = 1000000;

  localparam logic [31:0] ECALL_CODE = 32'h22;

endpackage

// File: rtl/tick_gen.sv
// Selectable-rate tick: one-cycle pulse every DIVsel cycles; a rate change
// restarts the interval and suppresses the tick in the changing cycle.
module tick_gen
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned DIV0 = DIV0_DEF,
  parameter int unsigned DIV1 = DIV1_DEF,
  parameter int unsigned DIV2 = DIV2_DEF,
  parameter int unsigned DIV3 = DIV3_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] clk_sel,
  output logic       tick
);

  logic [31:0] cnt;
  logic [31:0] div_m1;
  logic [1:0]  sel_q;
  logic        sel_chg;

  always_comb begin
    div_m1 = 32'(DIV0) - 32'd1;
    case (clk_sel)
      2'b00:   div_m1 = 32'(DIV0) - 32'd1;
      2'b01:   div_m1 = 32'(DIV1) - 32'd1;
      2'b10:   div_m1 = 32'(DIV2) - 32'd1;
      default: div_m1 = 32'(DIV3) - 32'd1;
    endcase
  end

  assign sel_chg = (clk_sel != sel_q);
  assign tick    = !sel_chg && (cnt == div_m1);

  // Wrap on >= so a stale count can never run past the selected interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      sel_q <= 2'b00;
    end else begin
      sel_q <= clk_sel;
      if (sel_chg || cnt >= div_m1)
        cnt <= '0;
      else
        cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/exec_controller.sv
// Execution sequencer: turns the selected tick into a one-cycle commit strobe
// and applies run/halt/single-step/breakpoint policy plus a commit counter.
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned DIV0  = DIV0_DEF,
  parameter int unsigned DIV1  = DIV1_DEF,
  parameter int unsigned DIV2  = DIV2_DEF,
  parameter int unsigned DIV3  = DIV3_DEF,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       CLK_Sel,
  input  logic             Go,
  input  logic             Step_Mode,
  input  logic             BP_En,
  input  logic [31:0]      BP_Addr,
  input  logic [31:0]      PC,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] PeriodNum
);

  state_t st;
  logic   tick;
  logic   go_p0, go_p1, go_p2;
  logic   go_pulse;
  logic   ovr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  tick_gen #(
    .DIV0(DIV0),
    .DIV1(DIV1),
    .DIV2(DIV2),
    .DIV3(DIV3)
  ) u_tick_gen (
    .clk    (CLK),
    .rst_n  (RST),
    .clk_sel(CLK_Sel),
    .tick   (tick)
  );

  // Go synchronizer (p0/p1) and edge-detect history (p2)
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      go_p0 <= 1'b0;
      go_p1 <= 1'b0;
      go_p2 <= 1'b0;
    end else begin
      go_p0 <= Go;
      go_p1 <= go_p0;
      go_p2 <= go_p1;
    end
  end

  assign go_pulse = go_p1 & ~go_p2;
  assign state    = st;

  // ovr lets the instruction that caused the halt retire once after resume.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st        <= RUN;
      cpu_en    <= 1'b0;
      halted    <= 1'b0;
      ovr       <= 1'b0;
      PeriodNum <= '0;
    end else begin
      cpu_en <= 1'b0;
      case (st)
        RUN, STEP: begin
          if (tick) begin
            if (!ovr && (halt_req || (BP_En && (PC == BP_Addr)))) begin
              st     <= HALT;
              halted <= 1'b1;
            end else begin
              cpu_en    <= 1'b1;
              ovr       <= 1'b0;
              PeriodNum <= sat_inc(PeriodNum);
              st        <= (Step_Mode || st == STEP) ? WAIT : RUN;
            end
          end
        end
        WAIT: begin
          if (go_pulse)
            st <= Step_Mode ? STEP : RUN;
        end
        HALT: begin
          if (go_pulse) begin
            ovr    <= 1'b1;
            halted <= 1'b0;
            st     <= Step_Mode ? STEP : RUN;
          end
        end
        default: st <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_controller.sv
// Scoreboard bench for exec_controller: expected commits are queued with the
// stimulus and matched against each cpu_en strobe.
module tb_exec_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  clk_sel;
  logic        go;
  logic        step_mode;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        halt_req;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [3:0]  period_num;

  typedef struct {
    int         cyc;
    logic [3:0] pn;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc;
  int   checks   = 0;
  int   failures = 0;

  exec_controller #(
    .DIV0(4), .DIV1(6), .DIV2(8), .DIV3(10), .CNT_W(4)
  ) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .CLK_Sel  (clk_sel),
    .Go       (go),
    .Step_Mode(step_mode),
    .BP_En    (bp_en),
    .BP_Addr  (bp_addr),
    .PC       (pc),
    .halt_req (halt_req),
    .cpu_en   (cpu_en),
    .state    (state),
    .halted   (halted),
    .PeriodNum(period_num)
  );

  always #5 clk = ~clk;

  // Cycle 1 is the period between reset release and the first rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 1;
    else        cyc <= cyc + 1;
  end

  // Minimal datapath stand-in: PC advances by 4 on each commit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  task automatic expect_commit(input int c, input int p);
    exp_t e;
    e.cyc = c;
    e.pn  = 4'(p);
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && cpu_en) begin
      chk("sb_pending", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("commit_pn", 64'(period_num), 64'(mon_e.pn));
        if (mon_e.cyc > 0) chk("commit_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  task automatic wait_cyc(input int n);
    int b = 0;
    while (cyc < n && b < 1000) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic press_go(input int hold);
    go = 1'b1;
    repeat (hold) @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset(input logic sm, input logic [1:0] sel);
    rst_n     = 1'b0;
    sbq.delete();
    go        = 1'b0;
    halt_req  = 1'b0;
    bp_en     = 1'b0;
    bp_addr   = 32'd0;
    step_mode = sm;
    clk_sel   = sel;
    repeat (3) @(negedge clk);
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_pn", 64'(period_num), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Free run with saturation
    do_reset(1'b0, 2'b00);
    for (int k = 0; k < 17; k++)
      expect_commit(5 + 4 * k, (k + 1 > 15) ? 15 : k + 1);
    wait_drain(120);

    // ecall halt, resume with override, halt again
    do_reset(1'b0, 2'b00);
    expect_commit(5, 1);
    expect_commit(9, 2);
    wait_drain(30);
    halt_req = 1'b1;
    repeat (6) @(negedge clk);
    chk("ecall_state", 64'(state), 64'd3);
    chk("ecall_halted", 64'(halted), 64'd1);
    chk("ecall_pn", 64'(period_num), 64'd2);
    expect_commit(0, 3);
    press_go(2);
    wait_drain(40);
    repeat (12) @(negedge clk);
    chk("rehalt_state", 64'(state), 64'd3);
    chk("rehalt_halted", 64'(halted), 64'd1);
    chk("rehalt_pn", 64'(period_num), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 64'(state), 64'd0);
    chk("async_rst_halted", 64'(halted), 64'd0);
    chk("async_rst_pn", 64'(period_num), 64'd0);

    // Breakpoint at 0x8
    do_reset(1'b0, 2'b00);
    bp_en   = 1'b1;
    bp_addr = 32'h8;
    expect_commit(5, 1);
    expect_commit(9, 2);
    wait_drain(30);
    repeat (8) @(negedge clk);
    chk("bp_state", 64'(state), 64'd3);
    chk("bp_pn", 64'(period_num), 64'd2);
    chk("bp_pc", 64'(pc), 64'h8);
    expect_commit(0, 3);
    expect_commit(0, 4);
    press_go(1);
    wait_drain(40);

    // Single step
    do_reset(1'b1, 2'b00);
    expect_commit(5, 1);
    wait_drain(30);
    repeat (3) @(negedge clk);
    chk("step_wait_state", 64'(state), 64'd1);
    repeat (12) @(negedge clk);
    chk("step_idle_pn", 64'(period_num), 64'd1);
    expect_commit(0, 2);
    press_go(2);
    wait_drain(30);
    chk("step2_state", 64'(state), 64'd1);
    expect_commit(0, 3);
    go = 1'b1;
    repeat (50) @(negedge clk);
    wait_drain(1);
    go = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_pn", 64'(period_num), 64'd3);
    chk("hold_state", 64'(state), 64'd1);

    // Rate change: 00->11 mid-interval, then 11->00 in a cycle where the
    // stale count equals the new terminal value
    do_reset(1'b0, 2'b00);
    expect_commit(5, 1);
    expect_commit(9, 2);
    expect_commit(21, 3);
    expect_commit(31, 4);
    expect_commit(39, 5);
    wait_cyc(10);
    clk_sel = 2'b11;
    wait_cyc(34);
    clk_sel = 2'b00;
    wait_drain(30);

    // Reset asserted in a tick cycle drops the pending commit
    do_reset(1'b0, 2'b00);
    expect_commit(5, 1);
    wait_drain(30);
    wait_cyc(8);
    rst_n = 1'b0;
    #1;
    chk("tickrst_pn", 64'(period_num), 64'd0);
    chk("tickrst_cpu_en", 64'(cpu_en), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tickrst_hold_cpu_en", 64'(cpu_en), 64'd0);
    end
    rst_n = 1'b1;
    expect_commit(5, 1);
    wait_drain(30);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
